// File: rtl/bg_pkg.sv
// Shared types and constants for the bandgap trim controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PWRUP  = 3'd1,
      ST_COARSE = 3'd2,
      ST_FINE   = 3'd3,
      ST_LOCKED = 3'd4
   } bg_state_t;

   // Chopper switch codes: c1 takes CHOP_A in phase A and CHOP_B in phase B, c2 the opposite.
   localparam logic [1:0] CHOP_A   = 2'b01;
   localparam logic [1:0] CHOP_B   = 2'b10;
   localparam logic [1:0] CHOP_OFF = 2'b00;

   localparam logic [3:0] OUT_SEL_IDLE = 4'hF;
   localparam logic [3:0] OUT_SEL_ACT  = 4'hE;
   localparam logic [7:0] DIODE_IDLE   = 8'h00;
   localparam logic [7:0] DIODE_ACT    = 8'hFF;

   typedef struct packed {
      bg_state_t  state;
      logic       pwrup;
      logic [7:0] idac_coarse;
      logic [7:0] idac_fine;
      logic [3:0] out_sel_n;
      logic [7:0] diode_sel;
      logic       res_stable;
      logic       ptat_en_n;
      logic [1:0] c1;
      logic [1:0] c2;
      logic       coarse;
      logic       valid;
   } bg_out_t;

   // Output values in reset and IDLE.
   localparam bg_out_t OUT_IDLE = '{
      state:       ST_IDLE,
      pwrup:       1'b0,
      idac_coarse: 8'h00,
      idac_fine:   8'h00,
      out_sel_n:   OUT_SEL_IDLE,
      diode_sel:   DIODE_IDLE,
      res_stable:  1'b0,
      ptat_en_n:   1'b1,
      c1:          CHOP_OFF,
      c2:          CHOP_OFF,
      coarse:      1'b0,
      valid:       1'b0
   };

endpackage

// File: rtl/bg_trim_ctrl_if.sv
// Control/status bundle between the trim controller and the analog bandgap.
// Latency: n/a (wiring only).
// Backpressure: none; enable is a level, start a single-cycle pulse.
interface bg_trim_ctrl_if;

   logic       enable;
   logic       start;
   logic       cmp_o;
   logic       pwrup;
   logic [7:0] idacCoarse;
   logic [7:0] idacFine;
   logic [3:0] idacOutSelect_n;
   logic [7:0] diodeSelect;
   logic       resStableSelect;
   logic       resPtatEnable_n;
   logic [1:0] c1;
   logic [1:0] c2;
   logic [2:0] state;
   logic       coarse;
   logic       valid;

   modport master (
      output enable, start, cmp_o,
      input  pwrup, idacCoarse, idacFine, idacOutSelect_n, diodeSelect,
             resStableSelect, resPtatEnable_n, c1, c2, state, coarse, valid
   );

   modport slave (
      input  enable, start, cmp_o,
      output pwrup, idacCoarse, idacFine, idacOutSelect_n, diodeSelect,
             resStableSelect, resPtatEnable_n, c1, c2, state, coarse, valid
   );

endinterface

// File: rtl/bg_sar8.sv
// 8-bit successive-approximation register, reused for the coarse and fine passes.
// Latency: code updates one clock after init/decide; result is combinational.
// Backpressure: none; clr > init > decide priority, decide ignored when idle.
module bg_sar8 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       init,
   input  logic       decide,
   input  logic       keep,
   output logic [7:0] code,
   output logic [7:0] result,
   output logic       last
);

   logic [7:0] trial_q;

   // Decided value of the current trial bit (cleared when the code is too high).
   assign result = keep ? code : (code & ~trial_q);
   assign last   = trial_q[0];

   // Code and one-hot trial pointer; a decision also sets the next lower bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         code    <= 8'h00;
         trial_q <= 8'h00;
      end else if (clr) begin
         code    <= 8'h00;
         trial_q <= 8'h00;
      end else if (init) begin
         code    <= 8'h80;
         trial_q <= 8'h80;
      end else if (decide) begin
         code    <= result | (trial_q >> 1);
         trial_q <= trial_q >> 1;
      end
   end

endmodule

// File: rtl/bg_trim_ctrl.sv
// Bandgap trim FSM: power-up wait, chopped SAR search of coarse then fine IDAC.
// Latency: outputs registered one clock behind the FSM; lock 169 clocks after start (defaults).
// Backpressure: none; start outside IDLE/LOCKED is dropped, enable low forces IDLE.
module bg_trim_ctrl
   import bg_pkg::*;
#(
   parameter int PWRUP_CYCLES  = 8,
   parameter int SETTLE_CYCLES = 4
) (
   input logic          clk,
   input logic          reset_n,
   bg_trim_ctrl_if.slave bus
);

   localparam logic [8:0] PW_LAST = 9'(PWRUP_CYCLES - 1);
   localparam logic [8:0] SMP_A   = 9'(SETTLE_CYCLES);
   localparam logic [8:0] SMP_B   = 9'(2 * SETTLE_CYCLES + 1);

   bg_state_t  state_q, state_d;
   logic [8:0] cnt_q, cnt_d;
   logic       a_q;
   logic [7:0] coarse_q;
   logic       sar_clr, sar_init, sar_dec, sar_keep, sar_last;
   logic       coarse_ld;
   logic [7:0] sar_code, sar_result;
   bg_out_t    out_d, out_q;

   // Code too high only when phase A says 1 and phase B says 0; anything else keeps the bit.
   assign sar_keep = !(a_q && !bus.cmp_o);

   bg_sar8 u_sar (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (sar_clr),
      .init    (sar_init),
      .decide  (sar_dec),
      .keep    (sar_keep),
      .code    (sar_code),
      .result  (sar_result),
      .last    (sar_last)
   );

   // FSM state and step counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 9'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter and SAR control.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 9'd1;
      sar_clr   = 1'b0;
      sar_init  = 1'b0;
      sar_dec   = 1'b0;
      coarse_ld = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d   = 9'd0;
            sar_clr = 1'b1;
            if (bus.start) state_d = ST_PWRUP;
         end
         ST_PWRUP: begin
            if (cnt_q == PW_LAST) begin
               state_d  = ST_COARSE;
               cnt_d    = 9'd0;
               sar_init = 1'b1;
            end
         end
         ST_COARSE, ST_FINE: begin
            if (cnt_q == SMP_B) begin
               cnt_d   = 9'd0;
               sar_dec = 1'b1;
               if (sar_last) begin
                  if (state_q == ST_COARSE) begin
                     coarse_ld = 1'b1;
                     sar_init  = 1'b1;
                     state_d   = ST_FINE;
                  end else begin
                     state_d   = ST_LOCKED;
                  end
               end
            end
         end
         ST_LOCKED: begin
            cnt_d = 9'd0;
            if (bus.start) state_d = ST_PWRUP;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 9'd0;
         end
      endcase
      if (!bus.enable) begin
         state_d   = ST_IDLE;
         cnt_d     = 9'd0;
         sar_clr   = 1'b1;
         coarse_ld = 1'b0;
      end
   end

   // Phase-A comparator sample and the held coarse result for the fine pass.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q      <= 1'b0;
         coarse_q <= 8'h00;
      end else begin
         if ((state_q == ST_COARSE || state_q == ST_FINE) && cnt_q == SMP_A)
            a_q <= bus.cmp_o;
         if (state_q == ST_IDLE)
            coarse_q <= 8'h00;
         else if (coarse_ld)
            coarse_q <= sar_result;
      end
   end

   // Decode the output image from the current state.
   always_comb begin
      out_d       = OUT_IDLE;
      out_d.state = state_q;
      if (state_q != ST_IDLE) begin
         out_d.pwrup       = 1'b1;
         out_d.out_sel_n   = OUT_SEL_ACT;
         out_d.diode_sel   = DIODE_ACT;
         out_d.ptat_en_n   = 1'b0;
         out_d.idac_coarse = coarse_q;
         out_d.idac_fine   = sar_code;
      end
      if (state_q == ST_COARSE || state_q == ST_FINE) begin
         out_d.c1 = (cnt_q <= SMP_A) ? CHOP_A : CHOP_B;
         out_d.c2 = (cnt_q <= SMP_A) ? CHOP_B : CHOP_A;
      end
      if (state_q == ST_COARSE) begin
         out_d.idac_coarse = sar_code;
         out_d.idac_fine   = 8'h00;
         out_d.coarse      = 1'b1;
      end
      if (state_q == ST_FINE || state_q == ST_LOCKED) out_d.res_stable = 1'b1;
      if (state_q == ST_LOCKED) out_d.valid = 1'b1;
   end

   // Output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_q <= OUT_IDLE;
      else          out_q <= out_d;
   end

   assign bus.state           = out_q.state;
   assign bus.pwrup           = out_q.pwrup;
   assign bus.idacCoarse      = out_q.idac_coarse;
   assign bus.idacFine        = out_q.idac_fine;
   assign bus.idacOutSelect_n = out_q.out_sel_n;
   assign bus.diodeSelect     = out_q.diode_sel;
   assign bus.resStableSelect = out_q.res_stable;
   assign bus.resPtatEnable_n = out_q.ptat_en_n;
   assign bus.c1              = out_q.c1;
   assign bus.c2              = out_q.c2;
   assign bus.coarse          = out_q.coarse;
   assign bus.valid           = out_q.valid;

endmodule

// File: tb/tb_bg_trim_ctrl.sv
// Bench for bg_trim_ctrl: cycle-indexed timeline model plus literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_bg_trim_ctrl;

   localparam int P      = 8;
   localparam int S      = 4;
   localparam int BITLEN = 2 * (S + 1);

   typedef struct packed {
      logic [2:0] st;
      logic       pw;
      logic [7:0] ic;
      logic [7:0] fc;
      logic [3:0] osel;
      logic [7:0] dio;
      logic       rss;
      logic       ptat_n;
      logic [1:0] c1;
      logic [1:0] c2;
      logic       crs;
      logic       vld;
   } obs_t;

   localparam obs_t IDLE_O = '{st: 3'd0, pw: 1'b0, ic: 8'h00, fc: 8'h00, osel: 4'hF,
                               dio: 8'h00, rss: 1'b0, ptat_n: 1'b1, c1: 2'b00,
                               c2: 2'b00, crs: 1'b0, vld: 1'b0};

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   bg_trim_ctrl_if bif();

   bg_trim_ctrl #(.PWRUP_CYCLES(P), .SETTLE_CYCLES(S)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   // Comparator model: too-high code gives 1 in phase A, inverted in phase B.
   logic [7:0] tgt_c, tgt_f;
   logic       stuck;
   logic [7:0] cur_code, cur_tgt;
   logic       gt;
   assign cur_code  = bif.coarse ? bif.idacCoarse : bif.idacFine;
   assign cur_tgt   = bif.coarse ? tgt_c : tgt_f;
   assign gt        = cur_code > cur_tgt;
   assign bif.cmp_o = stuck ? 1'b1 : ((bif.c1 == 2'b01) ? gt : ~gt);

   // Model state
   logic       from_locked;
   logic [7:0] held_c, held_f, exp_c, exp_f;
   logic       chk_on, lit_on;
   obs_t       lit_exp, lit_mask;
   string      lit_name;
   int         k;
   int         edge_i;
   int         n_vec = 0;
   int         n_err = 0;

   function automatic logic [7:0] sar_expect(logic [7:0] tgt, logic stk);
      logic [7:0] res = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] t;
         logic a, b;
         t = res | 8'(1 << i);
         a = stk ? 1'b1 : (t > tgt);
         b = stk ? 1'b1 : !(t > tgt);
         if (!(a && !b)) res = t;
      end
      return res;
   endfunction

   // Trial code while bit i is under test, given the final code f.
   function automatic logic [7:0] trial(logic [7:0] f, int i);
      int v;
      v = ((int'(f) >> (i + 1)) << (i + 1)) | (1 << i);
      return 8'(v);
   endfunction

   function automatic obs_t model_at(int kk);
      obs_t o;
      int   j, pos;
      o = IDLE_O;
      if (kk == 0 && !from_locked) return o;
      o.pw = 1'b1; o.osel = 4'hE; o.dio = 8'hFF; o.ptat_n = 1'b0;
      if (kk == 0) begin
         o.st = 3'd4; o.rss = 1'b1; o.vld = 1'b1; o.ic = held_c; o.fc = held_f;
      end else if (kk <= P) begin
         o.st = 3'd1; o.ic = held_c; o.fc = held_f;
      end else if (kk <= P + 16 * BITLEN) begin
         j   = (kk - P - 1) / BITLEN;
         pos = (kk - P - 1) % BITLEN;
         o.c1 = (pos <= S) ? 2'b01 : 2'b10;
         o.c2 = (pos <= S) ? 2'b10 : 2'b01;
         if (j < 8) begin
            o.st = 3'd2; o.crs = 1'b1; o.ic = trial(exp_c, 7 - j); o.fc = 8'h00;
         end else begin
            o.st = 3'd3; o.rss = 1'b1; o.ic = exp_c; o.fc = trial(exp_f, 15 - j);
         end
      end else begin
         o.st = 3'd4; o.rss = 1'b1; o.vld = 1'b1; o.ic = exp_c; o.fc = exp_f;
      end
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.st = bif.state; o.pw = bif.pwrup; o.ic = bif.idacCoarse; o.fc = bif.idacFine;
      o.osel = bif.idacOutSelect_n; o.dio = bif.diodeSelect; o.rss = bif.resStableSelect;
      o.ptat_n = bif.resPtatEnable_n; o.c1 = bif.c1; o.c2 = bif.c2;
      o.crs = bif.coarse; o.vld = bif.valid;
      return o;
   endfunction

   task automatic do_check(string name, obs_t act, obs_t exp, obs_t mask);
      obs_t am, em;
      am = act & mask;
      em = exp & mask;
      n_vec++;
      if (am !== em) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, am, em);
      end
   endtask

   // Single compare process: timeline model every cycle, plus literal requests.
   always @(negedge clk) begin
      obs_t act;
      act = sample();
      if (chk_on) begin
         do_check($sformatf("model k=%0d", k), act, model_at(k), '1);
         k++;
      end else begin
         k = 0;
      end
      if (lit_on) do_check(lit_name, act, lit_exp, lit_mask);
   end

   task automatic lit(string name, obs_t exp, obs_t mask);
      lit_name = name; lit_exp = exp; lit_mask = mask; lit_on = 1'b1;
      @(negedge clk);
      #1 lit_on = 1'b0;
   endtask

   task automatic go_to(int tgt);
      while (edge_i < tgt) begin
         @(posedge clk);
         edge_i++;
      end
      #1;
   endtask

   task automatic start_cal();
      exp_c = sar_expect(tgt_c, stuck);
      exp_f = sar_expect(tgt_f, stuck);
      @(negedge clk);
      bif.start = 1'b1;
      @(posedge clk);
      #1 bif.start = 1'b0;
      edge_i = 0;
      chk_on = 1'b1;
   endtask

   task automatic stop_cal();
      chk_on = 1'b0;
      @(negedge clk);
      #1;
   endtask

   initial begin
      obs_t m, x;
      reset_n = 1'b0; bif.enable = 1'b0; bif.start = 1'b0;
      stuck = 1'b0; tgt_c = 8'h00; tgt_f = 8'h00;
      chk_on = 1'b0; lit_on = 1'b0; from_locked = 1'b0;
      held_c = 8'h00; held_f = 8'h00; exp_c = 8'h00; exp_f = 8'h00;
      lit_name = ""; lit_exp = '0; lit_mask = '0; edge_i = 0;

      repeat (2) @(posedge clk);
      #1 lit("reset_values", IDLE_O, '1);
      reset_n = 1'b1; bif.enable = 1'b1;
      repeat (4) @(posedge clk);
      #1 lit("no_start_after_reset", IDLE_O, '1);

      // Full lock from IDLE: coarse 5A, fine C3.
      tgt_c = 8'h5A; tgt_f = 8'hC3;
      start_cal();
      go_to(88);  m = '0; m.crs = 1'b1; x = '0; x.crs = 1'b1;
      lit("coarse_high_88", x, m);
      go_to(89);  m = '0; m.crs = 1'b1; m.ic = 8'hFF; x = '0; x.ic = 8'h5A;
      lit("coarse_fall_89", x, m);
      go_to(168); m = '0; m.vld = 1'b1; x = '0;
      lit("valid_low_168", x, m);
      go_to(169); m = '0; m.vld = 1'b1; m.st = 3'h7; m.ic = 8'hFF; m.fc = 8'hFF;
      x = '0; x.vld = 1'b1; x.st = 3'd4; x.ic = 8'h5A; x.fc = 8'hC3;
      lit("lock_169", x, m);
      go_to(175);
      stop_cal();

      // Restart from LOCKED with boundary targets 00 / FF.
      from_locked = 1'b1; held_c = 8'h5A; held_f = 8'hC3;
      tgt_c = 8'h00; tgt_f = 8'hFF;
      start_cal();
      go_to(1); m = '0; m.vld = 1'b1; m.st = 3'h7; x = '0; x.st = 3'd1;
      lit("restart_valid_drop", x, m);
      go_to(175); m = '0; m.ic = 8'hFF; m.fc = 8'hFF; x = '0; x.ic = 8'h00; x.fc = 8'hFF;
      lit("boundary_codes", x, m);
      stop_cal();

      // Comparator stuck at 1: every bit kept.
      held_c = 8'h00; held_f = 8'hFF; stuck = 1'b1;
      start_cal();
      go_to(175); m = '0; m.ic = 8'hFF; m.fc = 8'hFF; x = '0; x.ic = 8'hFF; x.fc = 8'hFF;
      lit("stuck_codes", x, m);
      stop_cal();

      // Abort with enable low sampled at clock 50.
      stuck = 1'b0; held_c = 8'hFF; held_f = 8'hFF; tgt_c = 8'h5A; tgt_f = 8'hC3;
      start_cal();
      go_to(49);
      bif.enable = 1'b0; chk_on = 1'b0;
      go_to(51);
      lit("abort_idle_51", IDLE_O, '1);
      bif.start = 1'b1;
      @(posedge clk);
      #1 bif.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 lit("start_ignored_disabled", IDLE_O, '1);
      bif.enable = 1'b1;
      repeat (3) @(posedge clk);
      #1 lit("idle_after_enable", IDLE_O, '1);

      // Reset mid-FINE, then a fresh calibration with targets FF / 00.
      from_locked = 1'b0; held_c = 8'h00; held_f = 8'h00;
      start_cal();
      go_to(120);
      reset_n = 1'b0; chk_on = 1'b0;
      lit("reset_mid_fine", IDLE_O, '1);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 lit("idle_after_reset", IDLE_O, '1);
      tgt_c = 8'hFF; tgt_f = 8'h00;
      start_cal();
      go_to(175); m = '0; m.ic = 8'hFF; m.fc = 8'hFF; x = '0; x.ic = 8'hFF; x.fc = 8'h00;
      lit("final_codes_ff_00", x, m);
      stop_cal();

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bg_trim_ctrl.md
BG_TRIM_CTRL -- requirements
Module: bg_trim_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter: PWRUP_CYCLES, default 8, core power-up wait in clocks (range 1..255).
REQ-003 Parameter: SETTLE_CYCLES, default 4, analog settle wait before each comparator sample (range 1..255).
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  level; low aborts any calibration and holds IDLE.
REQ-007 start  in  1  single-cycle pulse; starts calibration from IDLE or LOCKED.
REQ-008 cmp_o  in  1  comparator output, VP>VN in chop phase A, polarity inverted in phase B; synchronous to clk.
REQ-009 pwrup  out  1  bandgap core power-up.
REQ-010 idacCoarse  out  8  coarse IDAC code.
REQ-011 idacFine  out  8  fine IDAC code.
REQ-012 idacOutSelect_n  out  4  IDAC output routing, active-low.
REQ-013 diodeSelect  out  8  diode-array enables.
REQ-014 resStableSelect  out  1  stable resistor select.
REQ-015 resPtatEnable_n  out  1  PTAT resistor enable, active-low.
REQ-016 c1, c2  out  2 each  comparator chopper switch controls.
REQ-017 state  out  3  FSM state code.
REQ-018 coarse  out  1  high while the coarse search runs.
REQ-019 valid  out  1  high while codes are locked.

Function
REQ-020 FSM states and encodings SHALL be IDLE=0, PWRUP=1, COARSE=2, FINE=3, LOCKED=4; state SHALL output the current encoding.
REQ-021 IDLE->PWRUP SHALL occur on start=1 with enable=1; PWRUP SHALL last exactly PWRUP_CYCLES clocks, then go to COARSE.
REQ-022 COARSE SHALL binary-search (SAR) idacCoarse from bit 7 to bit 0; FINE SHALL then do the same on idacFine, with idacCoarse held; FINE->LOCKED follows bit 0.
REQ-023 On entering COARSE, idacCoarse SHALL be 8'h80 and idacFine 8'h00; on entering FINE, idacFine SHALL be 8'h80.
REQ-024 Per bit: phase A (c1=2'b01, c2=2'b10) for SETTLE_CYCLES clocks, then sample cmp_o as a; phase B (c1=2'b10, c2=2'b01) for SETTLE_CYCLES clocks, then sample cmp_o as b.
REQ-025 Each sample SHALL take one clock, giving exactly 2*(SETTLE_CYCLES+1) clocks per bit.
REQ-026 Bit decision: clear the trial bit if a=1 and b=0 (code too high); otherwise keep it. Inconsistent chop results (a==b) SHALL keep the bit.
REQ-027 In the same clock as the decision, the next lower bit SHALL be set to 1 as the new trial bit.
REQ-028 LOCKED SHALL hold both codes and valid=1; start in LOCKED SHALL restart at PWRUP; the codes SHALL keep their locked values until COARSE entry.
REQ-029 enable=0 in any state SHALL force IDLE on the next clock; all outputs then take their reset values, and start is ignored while enable=0.
REQ-030 start during PWRUP, COARSE or FINE SHALL be ignored.
REQ-031 Outputs in PWRUP, COARSE, FINE and LOCKED: pwrup=1, idacOutSelect_n=4'b1110, diodeSelect=8'hFF, resPtatEnable_n=0.
REQ-032 resStableSelect SHALL be 1 in FINE and LOCKED only; coarse SHALL be 1 in COARSE only.
REQ-033 c1 and c2 SHALL be 2'b00 outside COARSE and FINE.
REQ-034 Timing: valid SHALL rise exactly PWRUP_CYCLES + 16*2*(SETTLE_CYCLES+1) + 1 clocks after the edge sampling start (169 with defaults).
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 On reset_n low: state=IDLE, pwrup=0, idacCoarse=idacFine=8'h00, idacOutSelect_n=4'hF, diodeSelect=8'h00, resStableSelect=0, resPtatEnable_n=1, c1=c2=2'b00, coarse=0, valid=0, counters cleared.
REQ-037 Reset deassertion SHALL NOT start calibration; a start pulse is required.

Structure
REQ-038 A shared package bg_pkg SHALL hold the state enum, the chop-phase constants (2'b01/2'b10) and the idle output constants.
REQ-039 One sub-module, bg_sar8, SHALL implement the 8-bit SAR register (init, trial-bit set, decision, done); it SHALL be instantiated once and reused for the coarse and fine passes.

Verification
REQ-040 Coarse pass: defaults, model cmp = (idacCoarse>8'h5A) in phase A, inverted in phase B, start -> idacCoarse=8'h5A, coarse falls at clock 89.
REQ-041 Full lock: same model, plus fine target 8'hC3 with the model on idacFine in FINE -> idacCoarse=8'h5A, idacFine=8'hC3, valid=1 at clock 169.
REQ-042 Boundaries: targets 8'h00 and 8'hFF -> final codes 8'h00 and 8'hFF respectively.
REQ-043 Chop inconsistency: cmp_o stuck at 1 -> every bit kept, idacCoarse=idacFine=8'hFF.
REQ-044 Abort: enable low at clock 50 -> state=IDLE and all outputs at reset values by clock 51; a start pulse while enable=0 is ignored.
REQ-045 Reset and restart: reset_n low mid-FINE -> immediate reset values; start in LOCKED -> valid drops next clock, state=PWRUP.
